order_bit_deserializer: RTL

Serial-to-parallel receive stage downstream of `toplevel`, consuming its 1-bit `dataout` stream as `datain`. It hunts for a sync word and shifts in a fixed-length order message MSB-first. When the build includes parity, it also checks an even-parity bit. Completed messages are presented on a valid/ready output register for the order-book logic.

---
 rtl/fin_msg_pkg.sv | 21 ++
 rtl/serial_sync_detect.sv | 40 ++++
 rtl/order_bit_deserializer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fin_msg_pkg.sv
// Shared definitions for the order-message receive path: message layout,
// framing constants and the deserializer state encoding.
package fin_msg_pkg;

    localparam logic [7:0] ORDER_SYNC_WORD = 8'hA5;
    localparam int         ORDER_PAYLOAD_W = 64;

    typedef struct packed {
        logic [31:0] price;
        logic [23:0] qty;
        logic [6:0]  symbol;
        logic        side;    // 1 = buy
    } order_msg_t;

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        PARITY
    } deser_state_e;

endpackage

// File: rtl/serial_sync_detect.sv
// Sliding sync-word detector: shifts the serial stream into a SYNC_W-bit
// register and flags when the updated contents equal SYNC_WORD.
module serial_sync_detect #(
    parameter int               SYNC_W    = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hA5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic din,
    output logic match
);

    logic [SYNC_W-1:0] sreg_q;
    logic [SYNC_W-1:0] sreg_d;
    logic [SYNC_W-1:0] shifted;

    assign shifted = {sreg_q[SYNC_W-2:0], din};
    // Compare against the post-shift value so a match is seen on the very bit that completes it.
    assign match   = en && (shifted == SYNC_WORD);

    always_comb begin
        sreg_d = sreg_q;
        if (clr) begin
            sreg_d = '0;
        end else if (en) begin
            sreg_d = shifted;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

endmodule

// File: rtl/order_bit_deserializer.sv
// Serial order-message receiver: sync hunt, MSB-first payload capture and a
// valid/ready output register. Define ORDER_DESER_PARITY_EN for an even-parity bit.
module order_bit_deserializer
    import fin_msg_pkg::*;
#(
    parameter int                SYNC_W    = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD = ORDER_SYNC_WORD,
    parameter int                PAYLOAD_W = ORDER_PAYLOAD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 datain,
    output logic [PAYLOAD_W-1:0] frame_data,
    output logic                 frame_valid,
    input  logic                 frame_ready,
    output logic                 parity_err,
    output logic                 overflow
);

    localparam int               CNT_W    = $clog2(PAYLOAD_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PAYLOAD_W - 1);

    deser_state_e          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PAYLOAD_W-1:0]  pay_q, pay_d;
    logic [PAYLOAD_W-1:0]  frame_data_q, frame_data_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  sync_shift;
    logic                  sync_clr;
    logic                  sync_match;
    logic                  complete;
`ifdef ORDER_DESER_PARITY_EN
    logic                  parity_err_q, parity_err_d;
`endif

    assign sync_shift = en && (state_q == HUNT);

    serial_sync_detect #(
        .SYNC_W    (SYNC_W),
        .SYNC_WORD (SYNC_WORD)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .en    (sync_shift),
        .clr   (sync_clr),
        .din   (datain),
        .match (sync_match)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pay_d    = pay_q;
        sync_clr = 1'b0;
        complete = 1'b0;
`ifdef ORDER_DESER_PARITY_EN
        parity_err_d = 1'b0;
`endif
        if (en) begin
            case (state_q)
                HUNT: begin
                    if (sync_match) begin
                        state_d = PAYLOAD;
                        cnt_d   = '0;
                    end
                end
                PAYLOAD: begin
                    pay_d = {pay_q[PAYLOAD_W-2:0], datain};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
`ifdef ORDER_DESER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d  = HUNT;
                        sync_clr = 1'b1;
                        complete = 1'b1;
`endif
                    end
                end
`ifdef ORDER_DESER_PARITY_EN
                PARITY: begin
                    state_d  = HUNT;
                    sync_clr = 1'b1;
                    // Even parity over payload plus parity bit: odd XOR means corruption.
                    if (^{pay_q, datain}) begin
                        parity_err_d = 1'b1;
                    end else begin
                        complete = 1'b1;
                    end
                end
`endif
                default: state_d = HUNT;
            endcase
        end
    end

    // Output register: a completion may reload in the same cycle the old message is accepted.
    always_comb begin
        frame_data_d  = frame_data_q;
        frame_valid_d = frame_valid_q && !frame_ready;
        overflow_d    = 1'b0;
        if (complete) begin
            if (!frame_valid_q || frame_ready) begin
                frame_data_d  = pay_d;
                frame_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            cnt_q         <= '0;
            pay_q         <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pay_q         <= pay_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            overflow_q    <= overflow_d;
        end
    end

`ifdef ORDER_DESER_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign overflow    = overflow_q;

endmodule
